// File: rtl/rv_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from EX resolution, plus wrapping branch/mispredict performance counters.
module rv_branch_predictor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_f,
  output logic                  pred_taken_f,
  output logic [ADDR_WIDTH-1:0] pred_target_f,
  output logic [ADDR_WIDTH-1:0] pred_pc_next_f,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_br,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  input  logic                  flush_all,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  cnt_branch,
  output logic [CNT_WIDTH-1:0]  cnt_mispred
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_branch_q, cnt_mispred_q;

  logic [IDX_W-1:0]     idx_f, idx_u;
  logic [TAG_WIDTH-1:0] tag_f, tag_u;
  logic                 hit_f, uhit, act_taken;

  logic                  ent_we;
  logic                  valid_d;
  logic [TAG_WIDTH-1:0]  tag_d;
  logic [ADDR_WIDTH-1:0] target_d;
  logic [1:0]            ctr_d;

  // Only the index and tag fields of the PCs are consumed by the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f, upd_pc};

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[TAG_LO+TAG_WIDTH-1:TAG_LO];
  assign idx_u = upd_pc[IDX_W+1:2];
  assign tag_u = upd_pc[TAG_LO+TAG_WIDTH-1:TAG_LO];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f   = hit_f && ctr_q[idx_f][1];
  assign pred_target_f  = hit_f ? target_q[idx_f] : '0;
  assign pred_pc_next_f = pred_taken_f ? pred_target_f : pc_f + ADDR_WIDTH'(4);

  assign act_taken   = upd_is_br && upd_taken;
  assign mispredict  = upd_valid &&
                       ((upd_pred_taken != act_taken) ||
                        (act_taken && upd_pred_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = act_taken ? upd_target : upd_pc + ADDR_WIDTH'(4);

  assign uhit = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

  always_comb begin
    ent_we   = 1'b0;
    valid_d  = valid_q[idx_u];
    tag_d    = tag_q[idx_u];
    target_d = target_q[idx_u];
    ctr_d    = ctr_q[idx_u];
    if (upd_valid && !flush_all) begin
      if (upd_is_br) begin
        if (uhit) begin
          ent_we = 1'b1;
          if (upd_taken) begin
            ctr_d    = (ctr_q[idx_u] == 2'b11) ? 2'b11 : ctr_q[idx_u] + 2'd1;
            target_d = upd_target;
          end else begin
            ctr_d = (ctr_q[idx_u] == 2'b00) ? 2'b00 : ctr_q[idx_u] - 2'd1;
          end
        end else if (upd_taken) begin
          ent_we   = 1'b1;
          valid_d  = 1'b1;
          tag_d    = tag_u;
          target_d = upd_target;
          ctr_d    = 2'b10;
        end
      end else if (uhit) begin
        // A non-branch matched the entry: the entry aliases a stale branch.
        ent_we  = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (ent_we) begin
      valid_q[idx_u]  <= valid_d;
      tag_q[idx_u]    <= tag_d;
      target_q[idx_u] <= target_d;
      ctr_q[idx_u]    <= ctr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (upd_valid && upd_is_br) cnt_branch_q <= cnt_branch_q + 1'b1;
      if (mispredict)             cnt_mispred_q <= cnt_mispred_q + 1'b1;
    end
  end

  assign cnt_branch  = cnt_branch_q;
  assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Self-checking bench for rv_branch_predictor: directed vector table, hand sequences
// and randomized traffic against a behavioural BTB model.
module tb_rv_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f, pred_pc_next_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br, upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_all;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] cnt_branch, cnt_mispred;

  logic        pred_taken_f4, mispredict4;
  logic [31:0] pred_target_f4, pred_pc_next_f4, redirect_pc4;
  logic [3:0]  cnt_branch4, cnt_mispred4;

  always #5 clk = ~clk;

  rv_branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .pred_pc_next_f(pred_pc_next_f),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_all(flush_all),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  rv_branch_predictor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f4), .pred_target_f(pred_target_f4),
    .pred_pc_next_f(pred_pc_next_f4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_all(flush_all),
    .mispredict(mispredict4), .redirect_pc(redirect_pc4),
    .cnt_branch(cnt_branch4), .cnt_mispred(cnt_mispred4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one record per BTB slot, counters as plain integers.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_cb, m_cm;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / 64) % 256;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cb = '0; m_cm = '0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_mispred();
    bit act;
    act = upd_is_br && upd_taken;
    return upd_valid && ((upd_pred_taken != act) ||
                         (act && upd_pred_taken && upd_pred_target != upd_target));
  endfunction

  function automatic void m_train();
    int unsigned i;
    if (m_mispred()) m_cm = m_cm + 1;
    if (upd_valid && upd_is_br) m_cb = m_cb + 1;
    i = m_idx(upd_pc);
    if (flush_all) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (upd_is_br) begin
        if (m_hit(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
        end
      end else if (m_hit(upd_pc)) begin
        m_valid[i] = 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit          hit, ept;
    logic [31:0] etgt, enext, eredir;
    hit    = m_hit(pc_f);
    ept    = hit && (m_ctr[m_idx(pc_f)] >= 2);
    etgt   = hit ? m_tgt[m_idx(pc_f)] : 32'h0;
    enext  = ept ? etgt : pc_f + 32'd4;
    eredir = (upd_is_br && upd_taken) ? upd_target : upd_pc + 32'd4;
    chk("pred_taken", 32'(pred_taken_f), 32'(ept));
    chk("pred_target", pred_target_f, etgt);
    chk("pred_pc_next", pred_pc_next_f, enext);
    chk("mispredict", 32'(mispredict), 32'(m_mispred()));
    chk("redirect_pc", redirect_pc, eredir);
    chk("cnt_branch", cnt_branch, m_cb);
    chk("cnt_mispred", cnt_mispred, m_cm);
    chk("cnt_branch_w4", 32'(cnt_branch4), 32'(m_cb[3:0]));
    chk("cnt_mispred_w4", 32'(cnt_mispred4), 32'(m_cm[3:0]));
  endtask

  // Inputs are already applied (posedge+1); check mid-cycle, then advance one edge.
  task automatic tick();
    #1;
    check_model();
    m_train();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid = 0; upd_pc = '0; upd_is_br = 0; upd_taken = 0; upd_target = '0;
    upd_pred_taken = 0; upd_pred_target = '0; flush_all = 0;
  endtask

  function automatic logic [31:0] gen_pc();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0) return $urandom();
    if (r == 1) return 32'hFFFF_FFFC;
    return 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        br, tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic        e_pt;
    logic [31:0] e_next;
    logic        e_mp;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [21];

  initial begin
    // pc, uv, upc, br, tk, tgt, pt, ptgt, fl | e_pt, e_next, e_mp, e_redir
    vecs[0]  = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h4};
    vecs[1]  = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h0,   0, 0, 32'h104, 1, 32'h80};
    vecs[2]  = '{32'h100, 1, 32'h100, 1, 0, 32'h0,   1, 32'h80,  0, 1, 32'h80,  1, 32'h104};
    vecs[3]  = '{32'h100, 1, 32'h100, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h104};
    vecs[4]  = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h0,   0, 0, 32'h104, 1, 32'h80};
    vecs[5]  = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h0,   0, 0, 32'h104, 1, 32'h80};
    vecs[6]  = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80,  0, 1, 32'h80,  0, 32'h80};
    vecs[7]  = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80,  0, 1, 32'h80,  0, 32'h80};
    vecs[8]  = '{32'h100, 1, 32'h100, 1, 0, 32'h0,   1, 32'h80,  0, 1, 32'h80,  1, 32'h104};
    vecs[9]  = '{32'h100, 1, 32'h100, 0, 1, 32'h999, 1, 32'h80,  0, 1, 32'h80,  1, 32'h104};
    vecs[10] = '{32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h0,   0, 0, 32'h104, 1, 32'h80};
    vecs[11] = '{32'h140, 1, 32'h140, 1, 1, 32'h40,  0, 32'h0,   0, 0, 32'h144, 1, 32'h40};
    vecs[12] = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h4};
    vecs[13] = '{32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  0, 32'h4};
    vecs[14] = '{32'h200, 1, 32'h200, 1, 1, 32'h300, 0, 32'h0,   0, 0, 32'h204, 1, 32'h300};
    vecs[15] = '{32'h200, 1, 32'h200, 1, 1, 32'h340, 1, 32'h300, 0, 1, 32'h300, 1, 32'h340};
    vecs[16] = '{32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h340, 0, 32'h4};
    vecs[17] = '{32'h200, 1, 32'h104, 1, 1, 32'h500, 0, 32'h0,   1, 1, 32'h340, 1, 32'h500};
    vecs[18] = '{32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h204, 0, 32'h4};
    vecs[19] = '{32'h104, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 0, 32'h4};
    vecs[20] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0,
                 0, 32'h0, 0, 32'h0};

    rst_n = 0;
    pc_f  = 32'h100;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pred_taken", 32'(pred_taken_f), 32'h0);
    chk("reset_pred_next", pred_pc_next_f, 32'h104);
    chk("reset_cnt_branch", cnt_branch, 32'h0);
    chk("reset_cnt_mispred", cnt_mispred, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      pc_f = vecs[i].pc; upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
      upd_is_br = vecs[i].br; upd_taken = vecs[i].tk; upd_target = vecs[i].tgt;
      upd_pred_taken = vecs[i].pt; upd_pred_target = vecs[i].ptgt; flush_all = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_pred_taken", i), 32'(pred_taken_f), 32'(vecs[i].e_pt));
      chk($sformatf("vec%0d_pred_next", i), pred_pc_next_f, vecs[i].e_next);
      chk($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_mp));
      chk($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].e_redir);
      tick();
    end
    idle_inputs();
    chk("table_cnt_branch", cnt_branch, 32'd13);
    chk("table_cnt_mispred", cnt_mispred, 32'd11);

    // Asynchronous reset mid-cycle clears counters without waiting for an edge.
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_cnt_branch", cnt_branch, 32'h0);
    chk("async_rst_cnt_mispred", cnt_mispred, 32'h0);
    pc_f = 32'h200;
    #1;
    chk("async_rst_pred_taken", 32'(pred_taken_f), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // 16 resolved branches wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      upd_valid = 1; upd_is_br = 1; upd_taken = 0; upd_pc = 32'h2000 + 32'(i * 4);
      upd_pred_taken = 0;
      tick();
    end
    idle_inputs();
    #1;
    chk("wrap_cnt_branch_w4", 32'(cnt_branch4), 32'h0);
    chk("wrap_cnt_branch", cnt_branch, 32'd16);

    for (int n = 0; n < 3000; n++) begin
      pc_f       = gen_pc();
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = gen_pc();
      upd_is_br  = ($urandom_range(0, 4) != 0);
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = gen_pc();
      if ($urandom_range(0, 3) != 0) begin
        upd_pred_taken  = m_hit(upd_pc) && (m_ctr[m_idx(upd_pc)] >= 2);
        upd_pred_target = m_hit(upd_pc) ? m_tgt[m_idx(upd_pc)] : 32'h0;
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = gen_pc();
      end
      flush_all = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_branch_predictor.md
Name: rv_branch_predictor

Overview:
- Parametrised fetch-stage predictor for the 5-stage RV32 pipeline. It replaces the fixed "predict not-taken, resolve in EX" next-PC scheme.
- Direct-mapped BTB with per-entry 2-bit saturating counters. Produces a predicted next PC in F, is trained from EX resolution, and raises mispredict/redirect toward the hazard controller (flushD/flushE).
- Carries saturating-free performance counters for branch and mispredict counts.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- ENTRIES, 16, BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- TAG_WIDTH, 8, tag bits taken from pc[IDX_W+2+TAG_WIDTH-1 : IDX_W+2].
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  ADDR_WIDTH  current fetch PC.
- pred_taken_f  out  1  prediction for pc_f.
- pred_target_f  out  ADDR_WIDTH  BTB target for pc_f; 0 on miss.
- pred_pc_next_f  out  ADDR_WIDTH  pred_taken_f ? pred_target_f : pc_f+4.
- upd_valid  in  1  an instruction is resolving in EX this cycle (not a bubble).
- upd_pc  in  ADDR_WIDTH  PC of the resolving instruction.
- upd_is_br  in  1  the resolving instruction is a branch, JAL or JALR.
- upd_taken  in  1  actual outcome; ignored (treated as 0) when upd_is_br=0.
- upd_target  in  ADDR_WIDTH  actual target when taken.
- upd_pred_taken  in  1  pred_taken_f carried down the pipe with this instruction.
- upd_pred_target  in  ADDR_WIDTH  pred_target_f carried down the pipe.
- flush_all  in  1  invalidate all BTB entries (fence.i).
- mispredict  out  1  redirect required this cycle.
- redirect_pc  out  ADDR_WIDTH  correct next PC when mispredict=1.
- cnt_branch  out  CNT_WIDTH  resolved branches (upd_valid & upd_is_br).
- cnt_mispred  out  CNT_WIDTH  mispredicts.

Behaviour:
- Index and tag: idx(pc)=pc[IDX_W+1:2]; tag(pc)=pc[IDX_W+2+TAG_WIDTH-1:IDX_W+2]. Per-entry state is {valid, tag, target, ctr[1:0]}.
- Lookup (combinational, zero latency): hit = valid[idx] & tag match; pred_taken_f = hit & ctr[1]. The table is read before any same-edge write, with no write-to-read bypass. A lookup and an update to the same index in one cycle returns the old entry.
- Effective outcome: act_taken = upd_is_br & upd_taken.
- Mispredict detection (combinational from upd_* only): mispredict = upd_valid & ((upd_pred_taken != act_taken) | (act_taken & upd_pred_taken & upd_pred_target != upd_target)).
- Redirect: redirect_pc = act_taken ? upd_target : upd_pc+4. When mispredict=0, redirect_pc is don't-care but still driven by the same expression.
- Training on rising edge, only when upd_valid=1 and flush_all=0. Let e = entry[idx(upd_pc)] and uhit = e.valid & tag match:
  - upd_is_br=1, uhit=1: ctr = taken ? min(ctr+1,3) : max(ctr-1,0). Target is overwritten with upd_target only when taken.
  - upd_is_br=1, uhit=0, taken: allocate the entry (valid=1, tag, target=upd_target, ctr=2'b10), replacing any previous occupant.
  - upd_is_br=1, uhit=0, not taken: no change.
  - upd_is_br=0, uhit=1 (alias): clear valid for that entry.
  - upd_is_br=0, uhit=0: no change.
- flush_all: synchronous; clears every valid bit on the next edge and takes priority over a coincident update. That update is dropped, but its mispredict, redirect_pc and counters still act.
- Performance counters: increment on the edge when the condition holds (upd_valid & upd_is_br for cnt_branch; mispredict for cnt_mispred). They wrap modulo 2^CNT_WIDTH, are unaffected by flush_all, and are cleared only by reset.
- Reset (asynchronous; takes effect immediately, including mid-operation):
  - All valid=0, tags=0, targets=0, ctr=2'b01, counters=0.
  - Outputs: pred_taken_f=0, pred_target_f=0, pred_pc_next_f=pc_f+4, mispredict=0 while upd_valid=0.
- Arithmetic: all +4 and PC compares are ADDR_WIDTH wide; pc+4 wraps at 2^ADDR_WIDTH (0xFFFFFFFC+4=0).

Test Plan:
- Reset, then pc_f=0x100 -> pred_taken_f=0, pred_pc_next_f=0x104; both counters 0.
- Taken branch upd_pc=0x100, target 0x80, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, pc_f=0x100 gives pred_taken_f=1, pred_pc_next_f=0x80 (ctr=10); cnt_mispred=1.
- Same entry trained not-taken twice -> ctr 10→01→00. First update: mispredict=1, redirect_pc=0x104. Lookup then gives pred_taken_f=0. Three further taken updates saturate ctr at 11.
- Alias: ENTRIES=16, entry at 0x100 valid; resolve non-branch at 0x100 with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x104, entry invalidated. Conflicting taken branch at 0x140 (same idx, different tag) replaces the entry; lookup 0x100 then misses.
- JALR at 0x200 with stored target 0x300, actual 0x340, upd_pred_taken=1 -> mispredict=1, redirect_pc=0x340, target updated to 0x340.
- flush_all with coincident taken update -> all entries invalid, update not written, cnt_branch still +1. Reset asserted mid-run clears the counters immediately. Set CNT_WIDTH=4 and drive 16 branches -> cnt_branch wraps to 0.
